pc_sequencer: RTL



---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/next_pc_sel.sv | 28 ++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_sequencer shared types and constants.
// Fetch FSM states, instruction length, default vectors.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } state_e;

  localparam int unsigned ILEN_BYTES = 4;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/next_pc_sel.sv
// Priority select of jump / branch / pc+4 commit target.
// Ports: pc_i, jump_i/jump_target_i, branch_i/branch_target_i -> target_o, misaligned_o.
module next_pc_sel
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  // Sequential path wraps silently and is never alignment-checked.
  always_comb begin
    target_o     = pc_i + 32'(ILEN_BYTES);
    misaligned_o = 1'b0;
    if (jump_i) begin
      target_o     = jump_target_i;
      misaligned_o = |jump_target_i[1:0];
    end else if (branch_i) begin
      target_o     = branch_target_i;
      misaligned_o = |branch_target_i[1:0];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC fetch controller: computes next_pc and drives the imem fetch handshake.
// Ports: clk, reset (sync, high), pc -> next_pc, imem_req/addr/ready,
//   instr_valid, stall, branch/jump redirects, trap pulse, bad_addr.
// Option PC_SEQ_INSTRET_EN adds a 32-bit retired-instruction counter 'instret'.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        trap,
  output logic [31:0] bad_addr
`ifdef PC_SEQ_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  state_e      state_q, state_d;
  logic [31:0] bad_q, bad_d;
  logic [31:0] tgt;
  logic        mis;

  next_pc_sel u_sel (
    .pc_i            (pc),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .branch_i        (branch_taken),
    .branch_target_i (branch_target),
    .target_o        (tgt),
    .misaligned_o    (mis)
  );

  assign imem_addr = pc;
  assign bad_addr  = bad_q;

  // Redirect inputs only matter on commit, which already needs imem_ready.
  always_comb begin
    state_d     = state_q;
    bad_d       = bad_q;
    next_pc     = pc;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    trap        = 1'b0;
    unique case (state_q)
      BOOT: begin
        next_pc = RESET_VECTOR;
        state_d = FETCH;
      end
      FETCH: begin
        imem_req    = 1'b1;
        instr_valid = imem_ready;
        if (imem_ready && !stall) begin
          if (mis) begin
            next_pc = TRAP_VECTOR;
            bad_d   = tgt;
            state_d = TRAP;
          end else begin
            next_pc = tgt;
          end
        end
      end
      TRAP: begin
        trap    = 1'b1;
        state_d = FETCH;
      end
      default: begin
        next_pc = RESET_VECTOR;
        state_d = BOOT;
      end
    endcase
    // Reset overrides everything so pending redirects are dropped.
    if (reset) begin
      next_pc     = RESET_VECTOR;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      trap        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
    end
  end

`ifdef PC_SEQ_INSTRET_EN
  logic [31:0] instret_q;
  logic        retire;

  assign retire  = (state_q == FETCH) && imem_ready && !stall && !mis;
  assign instret = instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end
`endif

endmodule
